// File: rtl/writeback_commit_pkg.sv
// -----------------------------------------------------------------------------
// writeback_commit_pkg
//
// Purpose : Types and constants shared by the reorder buffer (ROB) and the
//           commit unit. The ROB produces t_rob_data entries and the commit
//           unit consumes them, so both sides agree on one layout.
//
// Contents:
//   SEQ_BITS        - width of the ROB sequence number (ROB depth 2^SEQ_BITS)
//   XLEN            - data / PC width
//   REG_ADDR_BITS   - architectural register index width
//   t_rob_data      - ROB entry {seq_num, pc, waddr, wdata, wen}
//   t_commit_state  - commit-unit FSM states
//   rob_writes_rf() - true when an entry really updates the register file
// -----------------------------------------------------------------------------
package writeback_commit_pkg;

  localparam int SEQ_BITS      = 2;
  localparam int XLEN          = 32;
  localparam int REG_ADDR_BITS = 5;

  typedef struct packed {
    logic [SEQ_BITS-1:0]      seq_num;
    logic [XLEN-1:0]          pc;
    logic [REG_ADDR_BITS-1:0] waddr;
    logic [XLEN-1:0]          wdata;
    logic                     wen;
  } t_rob_data;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } t_commit_state;

  // x0 is hard-wired to zero: such a write retires but must not reach the RF.
  function automatic logic rob_writes_rf(input t_rob_data entry);
    return entry.wen && (entry.waddr != '0);
  endfunction

endpackage

// File: rtl/commit_unit.sv
// -----------------------------------------------------------------------------
// commit_unit
//
// Purpose : Retires instructions from the front of the ROB in order. Each
//           dequeued entry is registered and presented one cycle later as an
//           architectural register-file write plus a retirement notification.
//           An expected-sequence counter checks that entries arrive in order;
//           any mismatch raises a sticky error flag (the entry still retires).
//           A halt request stops retirement through a RUN -> DRAIN -> HALTED
//           sequence and resumes when the request drops.
//
// Parameters:
//   p_seq_bits - sequence-number width; must equal writeback_commit_pkg::SEQ_BITS
//   p_cnt_bits - retire-counter width (only used with the counter enabled)
//
// Ports:
//   clk             in   clock, all state on rising edge
//   rst             in   asynchronous active-low reset
//   deq_front_en    out  dequeue request to the ROB front (combinational)
//   deq_front_rdy   in   ROB front entry valid
//   deq_front_data  in   ROB front entry (t_rob_data)
//   rf_wen          out  register-file write enable
//   rf_waddr        out  register-file write address
//   rf_wdata        out  register-file write data
//   commit_val      out  one instruction retired this cycle
//   commit_seq_num  out  sequence number of the retired instruction
//   commit_pc       out  PC of the retired instruction
//   halt_req        in   level request to stop retiring
//   halted          out  high while retirement is stopped
//   seq_err         out  sticky sequence-order error
//   retire_cnt      out  retired-instruction counter (COMMIT_UNIT_RETIRE_CNT_EN only)
//
// Configuration macro: COMMIT_UNIT_RETIRE_CNT_EN adds the retire_cnt output
// and its counter; without it neither exists.
// -----------------------------------------------------------------------------
module commit_unit
  import writeback_commit_pkg::*;
#(
  parameter int p_seq_bits = SEQ_BITS,
  parameter int p_cnt_bits = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     deq_front_en,
  input  logic                     deq_front_rdy,
  input  t_rob_data                deq_front_data,
  output logic                     rf_wen,
  output logic [REG_ADDR_BITS-1:0] rf_waddr,
  output logic [XLEN-1:0]          rf_wdata,
  output logic                     commit_val,
  output logic [p_seq_bits-1:0]    commit_seq_num,
  output logic [XLEN-1:0]          commit_pc,
  input  logic                     halt_req,
  output logic                     halted,
`ifdef COMMIT_UNIT_RETIRE_CNT_EN
  output logic [p_cnt_bits-1:0]    retire_cnt,
`endif
  output logic                     seq_err
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  t_commit_state             state_q,      state_d;
  logic [p_seq_bits-1:0]     exp_seq_q,    exp_seq_d;
  logic                      seq_err_q,    seq_err_d;
  logic                      commit_val_q, commit_val_d;
  logic                      rf_wen_q,     rf_wen_d;
  logic                      halted_q,     halted_d;
  logic [REG_ADDR_BITS-1:0]  rf_waddr_q,   rf_waddr_d;
  logic [XLEN-1:0]           rf_wdata_q,   rf_wdata_d;
  logic [XLEN-1:0]           commit_pc_q,  commit_pc_d;
  logic [p_seq_bits-1:0]     commit_seq_q, commit_seq_d;

  logic fire;

  // ---------------------------------------------------------------------------
  // Dequeue handshake. Gated by rst so nothing can be taken from the ROB while
  // reset is held; a handshake cut short by reset is simply never seen.
  // ---------------------------------------------------------------------------
  always_comb begin
    deq_front_en = rst && deq_front_rdy && (state_q == ST_RUN) && !halt_req;
  end

  assign fire = deq_front_en;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    exp_seq_d    = exp_seq_q;
    seq_err_d    = seq_err_q;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    commit_pc_d  = commit_pc_q;
    commit_seq_d = commit_seq_q;

    // Pulse outputs: high only in the cycle after a fire.
    commit_val_d = fire;
    rf_wen_d     = fire && rob_writes_rf(deq_front_data);

    if (fire) begin
      rf_waddr_d   = deq_front_data.waddr;
      rf_wdata_d   = deq_front_data.wdata;
      commit_pc_d  = deq_front_data.pc;
      commit_seq_d = deq_front_data.seq_num;
      // Counter advances on every fire, so one bad entry does not cascade into
      // errors on all the correctly ordered entries that follow it.
      exp_seq_d    = exp_seq_q + 1'b1;
      if (deq_front_data.seq_num != exp_seq_q) begin
        seq_err_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_RUN: begin
        // halt_req also blocks deq_front_en, so no fire coincides with this.
        if (halt_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // One cycle for the last registered retirement to be seen downstream.
        state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (!halt_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    // Registered so that halted is a clean flop output aligned with state_q.
    halted_d = (state_d == ST_HALTED);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      exp_seq_q    <= '0;
      seq_err_q    <= 1'b0;
      commit_val_q <= 1'b0;
      rf_wen_q     <= 1'b0;
      halted_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      commit_pc_q  <= '0;
      commit_seq_q <= '0;
    end else begin
      state_q      <= state_d;
      exp_seq_q    <= exp_seq_d;
      seq_err_q    <= seq_err_d;
      commit_val_q <= commit_val_d;
      rf_wen_q     <= rf_wen_d;
      halted_q     <= halted_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      commit_pc_q  <= commit_pc_d;
      commit_seq_q <= commit_seq_d;
    end
  end

  assign commit_val     = commit_val_q;
  assign commit_seq_num = commit_seq_q;
  assign commit_pc      = commit_pc_q;
  assign rf_wen         = rf_wen_q;
  assign rf_waddr       = rf_waddr_q;
  assign rf_wdata       = rf_wdata_q;
  assign halted         = halted_q;
  assign seq_err        = seq_err_q;

  // ---------------------------------------------------------------------------
  // Optional retire counter: counts cycles on which commit_val is high.
  // ---------------------------------------------------------------------------
`ifdef COMMIT_UNIT_RETIRE_CNT_EN
  logic [p_cnt_bits-1:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (commit_val_q) retire_cnt_d = retire_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: doc/commit_unit.md
COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 SHALL have parameter p_seq_bits, default 2, meaning the width of the ROB sequence number (ROB depth 2^p_seq_bits).
REQ-002 SHALL have parameter p_cnt_bits, default 32, meaning the retire-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port deq_front_en  output  1  dequeue request to the ROB front.
REQ-006 SHALL have port deq_front_rdy  input  1  ROB front entry valid.
REQ-007 SHALL have port deq_front_data  input  t_rob_data  ROB front entry {seq_num, pc, waddr, wdata, wen}.
REQ-008 SHALL have ports rf_wen / rf_waddr / rf_wdata  output  1/5/32  architectural register-file write port.
REQ-009 SHALL have ports commit_val / commit_seq_num / commit_pc  output  1/p_seq_bits/32  retirement notification.
REQ-010 SHALL have port halt_req  input  1  level request to stop retiring.
REQ-011 SHALL have port halted  output  1  high while retirement is stopped.
REQ-012 SHALL have port seq_err  output  1  sticky sequence-order error flag.

Function
REQ-013 SHALL implement a three-state FSM: RUN, DRAIN, HALTED.
REQ-014 SHALL drive deq_front_en = deq_front_rdy && state==RUN && !halt_req, combinationally; a dequeue "fires" when deq_front_en is high at a rising edge.
REQ-015 SHALL, on a fire, register the entry so that commit_val=1, commit_seq_num/commit_pc and rf_waddr/rf_wdata equal the entry on the following cycle (latency exactly 1).
REQ-016 SHALL set rf_wen = entry.wen && entry.waddr!=0 on that cycle; writes to x0 are suppressed but still retire (commit_val=1).
REQ-017 SHALL drive commit_val=0 and rf_wen=0 on any cycle following a cycle without a fire; rf_waddr/rf_wdata/commit_pc then hold their last values.
REQ-018 SHALL keep an expected-sequence counter, p_seq_bits wide, incremented by 1 per fire, wrapping from 2^p_seq_bits-1 to 0.
REQ-019 SHALL set seq_err when a fired entry's seq_num differs from the expected counter; seq_err stays high until reset and the entry still retires.
REQ-020 SHALL transition RUN->DRAIN when halt_req=1 at a rising edge (no fire that cycle).
REQ-021 SHALL transition DRAIN->HALTED unconditionally after one cycle, during which the pending output (if any) is presented and then cleared.
REQ-022 SHALL transition HALTED->RUN when halt_req=0; remain in HALTED otherwise; halted=1 only in HALTED.
REQ-023 SHALL ignore deq_front_rdy while not in RUN; the ROB entry is left untouched.

Reset
REQ-024 SHALL, while rst=0, asynchronously force state=RUN, expected counter=0, seq_err=0, commit_val=0, rf_wen=0, halted=0, rf_waddr/rf_wdata/commit_pc/commit_seq_num=0.
REQ-025 SHALL drive deq_front_en=0 while rst=0; a fire in progress when rst falls is discarded.

Configuration
REQ-026 SHALL, with COMMIT_UNIT_RETIRE_CNT_EN defined, add output retire_cnt (p_cnt_bits), reset to 0, incremented by 1 on each cycle with commit_val=1, wrapping at 2^p_cnt_bits.
REQ-027 SHALL, without COMMIT_UNIT_RETIRE_CNT_EN, omit the retire_cnt port and counter entirely.

Structure
REQ-028 SHALL take t_rob_data and the sequence-width constant from a shared package (writeback_commit_pkg), also used by the ROB.
REQ-029 SHALL be one flat module; no sub-module.

Verification
REQ-030 SHALL cover: reset release, ROB presents seq 0 pc=0x200 waddr=5 wdata=0xDEAD wen=1 -> next cycle rf_wen=1 rf_waddr=5 rf_wdata=0xDEAD commit_val=1 commit_seq_num=0.
REQ-031 SHALL cover: entry waddr=0 wen=1 -> rf_wen=0, commit_val=1.
REQ-032 SHALL cover: five back-to-back entries seq 0,1,2,3,0 -> five consecutive commit_val cycles, seq_err stays 0 across the wrap.
REQ-033 SHALL cover: entry seq 2 when expected 1 -> entry retires, seq_err=1 and remains 1 until rst=0.
REQ-034 SHALL cover: halt_req=1 while deq_front_rdy=1 -> deq_front_en=0, DRAIN one cycle, halted=1; halt_req=0 -> RUN, next entry fires.
REQ-035 SHALL cover: rst asserted mid-stream with commit_val=1 -> outputs 0 immediately, without waiting for a clock edge.
